// File: rtl/clz_normalizer_pkg.sv
// Shared types and constants for the multi-cycle leading-zero normalizer.
package clz_normalizer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;

  // Count reported for an all-zero operand
  localparam logic [CNT_W-1:0] ZERO_CNT = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/clz_normalizer_if.sv
// Start/busy/done handshake and data bus of the normalizer.
interface clz_normalizer_if;
  import clz_normalizer_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  count;
  logic              zero;

  modport master (output start, a, input busy, done, result, count, zero);
  modport slave  (input start, a, output busy, done, result, count, zero);

endinterface

// File: rtl/clz_normalizer_clz.sv
// Combinational leading-zero counter; reports DATA_W for an all-zero input.
module clz_normalizer_clz
  import clz_normalizer_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] clz_c
);

  // Ascending scan so the highest set bit determines the count
  always_comb begin
    clz_c = DATA_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (value[i]) clz_c = DATA_W'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/clz_normalizer.sv
// Multi-cycle normalizer: counts leading zeros once, then shifts left by at
// most STEP bits per cycle until the MSB is set.
module clz_normalizer
  import clz_normalizer_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  clz_normalizer_if.slave  bus
);

  localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP);

  state_e                    state_q, state_d;
  logic [DATA_W-1:0]         operand_q, operand_d;
  logic [DATA_W-1:0]         result_q, result_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      zero_q, zero_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [DATA_W-1:0]         clz_full;
  logic [CNT_W-1:0]          clz_cnt;
  logic [DATA_W-CNT_W-1:0]   unused_clz_hi;
  logic [CNT_W-1:0]          sh;
  logic [CNT_W-1:0]          rem_next;
  logic [DATA_W-1:0]         shifted;

  clz_normalizer_clz u_clz (
    .value (operand_q),
    .clz_c (clz_full)
  );

  assign clz_cnt       = clz_full[CNT_W-1:0];
  assign unused_clz_hi = clz_full[DATA_W-1:CNT_W];

  // Small shifter: only distances 0..STEP are built
  always_comb begin
    sh      = (rem_q < STEP_CNT) ? rem_q : STEP_CNT;
    shifted = operand_q;
    for (int unsigned i = 1; i <= STEP; i++) begin
      if (sh == CNT_W'(i)) shifted = operand_q << i;
    end
  end

  assign rem_next = rem_q - sh;

  // Next-state and datapath update; result is loaded on entry to DONE so it
  // is already valid while done is high
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    rem_d     = rem_q;
    count_d   = count_q;
    zero_d    = zero_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          operand_d = bus.a;
          state_d   = S_COUNT;
        end
      end
      S_COUNT: begin
        count_d = clz_cnt;
        rem_d   = clz_cnt;
        zero_d  = (clz_cnt == ZERO_CNT);
        if (clz_cnt == '0 || clz_cnt == ZERO_CNT) begin
          result_d = operand_q;
          state_d  = S_DONE;
        end else begin
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        operand_d = shifted;
        rem_d     = rem_next;
        if (rem_next == '0) begin
          result_d = shifted;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.count  = count_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Scoreboard bench for clz_normalizer at STEP=4 and STEP=16.
module tb_clz_normalizer;
  import clz_normalizer_pkg::*;

  typedef struct {
    logic [31:0] result;
    logic [5:0]  count;
    logic        zero;
    int          lat;
    int          n0;
    string       tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q16[$];

  clz_normalizer_if b4 ();
  clz_normalizer_if b16 ();

  clz_normalizer #(.STEP(4))  dut4  (.clk(clk), .reset(reset), .bus(b4.slave));
  clz_normalizer #(.STEP(16)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(input exp_t e, input logic [31:0] res, input logic [5:0] cnt,
                       input logic z, input logic bsy);
    check({e.tag, " result"},  res,              e.result);
    check({e.tag, " count"},   32'(cnt),         32'(e.count));
    check({e.tag, " zero"},    32'(z),           32'(e.zero));
    check({e.tag, " busy"},    32'(bsy),         32'h1);
    check({e.tag, " latency"}, 32'(cyc - e.n0),  32'(e.lat));
  endtask

  // Monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    if (b4.done === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL step4 unexpected done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q4.pop_front();
        score(e, b4.result, b4.count, b4.zero, b4.busy);
      end
    end
  end

  always @(negedge clk) begin
    if (b16.done === 1'b1) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL step16 unexpected done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q16.pop_front();
        score(e, b16.result, b16.count, b16.zero, b16.busy);
      end
    end
  end

  // Raise start at the current negedge (cycle 0) and queue the expected response
  task automatic issue(input bit use16, input logic [31:0] a, input logic [31:0] res,
                       input logic [5:0] cnt, input logic z, input int lat, input string tag);
    exp_t e;
    e = '{result: res, count: cnt, zero: z, lat: lat, n0: cyc, tag: tag};
    if (use16) begin
      b16.start = 1'b1; b16.a = a; q16.push_back(e);
    end else begin
      b4.start = 1'b1;  b4.a = a;  q4.push_back(e);
    end
  endtask

  task automatic release_start();
    b4.start  = 1'b0; b4.a  = 32'hDEAD_BEEF;
    b16.start = 1'b0; b16.a = 32'hDEAD_BEEF;
  endtask

  // Wait until all expected responses are seen, then step into the first IDLE cycle
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    #1;
    while ((q4.size() != 0 || q16.size() != 0) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (q4.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: pending %0d/%0d expected 0/0", tag, q4.size(), q16.size());
      q4.delete(); q16.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    b4.start = 1'b0;  b4.a  = '0;
    b16.start = 1'b0; b16.a = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy",   32'(b4.busy),   32'h0);
    check("reset done",   32'(b4.done),   32'h0);
    check("reset result", b4.result,      32'h0);
    check("reset count",  32'(b4.count),  32'h0);
    check("reset zero",   32'(b4.zero),   32'h0);
    check("reset busy16", 32'(b16.busy),  32'h0);
    reset = 1'b0;
    @(negedge clk);

    // MSB already set: no shift, busy only in cycles 1-2
    issue(0, 32'h8000_0000, 32'h8000_0000, 6'd0, 1'b0, 2, "msb");
    @(negedge clk); release_start();
    check("msb busy c1", 32'(b4.busy), 32'h1);
    @(negedge clk);
    check("msb busy c2", 32'(b4.busy), 32'h1);
    wait_idle("msb");
    check("msb busy c3", 32'(b4.busy), 32'h0);

    // Longest shift: 8 steps at STEP=4, 2 steps at STEP=16
    issue(0, 32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0, 10, "one s4");
    issue(1, 32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0, 4,  "one s16");
    @(negedge clk); release_start();
    wait_idle("one");

    // All-zero operand
    issue(0, 32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1, 2, "zero s4");
    issue(1, 32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1, 2, "zero s16");
    @(negedge clk); release_start();
    wait_idle("zero");

    // start held through the DONE cycle, operand changed mid-flight
    issue(0, 32'h00F0_1234, 32'hF012_3400, 6'd8, 1'b0, 4, "held");
    @(negedge clk); b4.a = 32'h0000_0001;
    repeat (4) @(negedge clk);
    release_start();
    check("held no restart", 32'(b4.busy), 32'h0);
    repeat (3) @(negedge clk);

    // Reset in the middle of SHIFT aborts without a done pulse
    b4.start = 1'b1; b4.a = 32'h0000_0003;
    @(negedge clk); release_start();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy",   32'(b4.busy),  32'h0);
    check("abort done",   32'(b4.done),  32'h0);
    check("abort result", b4.result,     32'h0);
    check("abort count",  32'(b4.count), 32'h0);
    check("abort zero",   32'(b4.zero),  32'h0);
    reset = 1'b0;
    @(negedge clk);
    issue(0, 32'h4000_0000, 32'h8000_0000, 6'd1, 1'b0, 3, "post abort");
    @(negedge clk); release_start();
    wait_idle("post abort");

    // Back-to-back: second start in the first IDLE cycle after done
    issue(0, 32'h0000_FFFF, 32'hFFFF_0000, 6'd16, 1'b0, 6, "b2b first");
    @(negedge clk); release_start();
    wait_idle("b2b first");
    check("b2b hold result idle", b4.result,     32'hFFFF_0000);
    check("b2b hold count idle",  32'(b4.count), 32'd16);
    issue(0, 32'h1000_0000, 32'h8000_0000, 6'd3, 1'b0, 3, "b2b second");
    @(negedge clk); release_start();
    check("b2b hold result c1", b4.result, 32'hFFFF_0000);
    wait_idle("b2b second");
    check("b2b final result", b4.result, 32'h8000_0000);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clz_normalizer.md
Name: clz_normalizer

Overview:
- Multi-cycle normalizer for the SoC ALU/FP path. Takes a 32-bit operand, counts its leading zeros, then left-shifts the operand until bit 31 is set.
- Returns the normalized value and the shift count, using a start/busy/done handshake.
- Replaces a full 32-bit barrel shifter with a small per-cycle shifter to save LUTs on the FPGA.
- Sits beside the ALU and is sequenced by the CPU execute FSM.

Parameters:
- STEP, 4, maximum left-shift distance per SHIFT cycle. Legal values are 1, 2, 4, 8 and 16.

Ports:
- clk  input  1  system clock. Everything is synchronous to the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe. Sampled only in IDLE.
- a  input  32  operand. Sampled on the edge where start is accepted.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, high while in DONE.
- result  output  32  normalized operand.
- count  output  6  leading-zero count, range 0..32.
- zero  output  1  high when the operand was all zeros.

Behaviour:
- Reset values (on a clk edge with reset high): state IDLE, busy 0, done 0, result 0, count 0, zero 0. Internal operand and remaining-shift registers are 0.
- Reset overrides start and any in-progress operation. An aborted operation produces no done pulse and leaves no partial result visible.
- States: IDLE, COUNT, SHIFT, DONE. Encoding is one-hot or binary, taken from the package.
- IDLE:
  - If start=1, latch a into the operand register and go to COUNT.
  - If start=0, stay in IDLE.
- COUNT:
  - The clz sub-module drives the leading-zero count combinationally from the operand register.
  - Register that value into count and into rem (6-bit remaining shift). Set zero = (clz==32).
  - If clz is 0 or 32, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - Each cycle, sh = min(rem, STEP). The operand shifts left by sh with zero fill, and rem decreases by sh.
  - When the updated rem is 0, go to DONE; otherwise stay in SHIFT.
  - Number of SHIFT cycles = ceil(clz/STEP).
- DONE:
  - done=1 and busy=1 for exactly one cycle. Copy the operand register to result.
  - Next state is IDLE.
- Outputs result, count and zero:
  - Update only as specified above. result is written in DONE; count and zero are written in COUNT.
  - Hold their values until the next accepted start.
  - count and zero may change during COUNT of a new operation. Consumers sample them only on done.
- Latency: start sampled at edge 0 → COUNT in cycle 1 → SHIFT in cycles 2..k+1 → DONE in cycle k+2, where k = ceil(clz/STEP).
  - Clz 0 or 32: done in cycle 2.
  - Worst case at STEP=4 (clz=31): done in cycle 10.
- start while busy is ignored. It is neither queued nor does it alter the in-flight operand.
- start asserted in the DONE cycle is ignored. The next start is accepted in IDLE, so the minimum issue interval is 3 cycles.
- Zero operand: count=32, zero=1, result=0, no SHIFT cycles.
- The operand MSB is guaranteed 1 at DONE for any nonzero input (invariant for assertions).

Decomposition:
- Shared package holds:
  - state encoding constants: S_IDLE, S_COUNT, S_SHIFT, S_DONE;
  - width constants: DATA_W=32, CNT_W=6;
  - the all-zero count value 6'd32.
- Sub-module: the existing clz block (32-bit in, 32-bit count out, low 6 bits used), instantiated once on the operand register.
- Everything else (FSM, step shifter, rem counter) stays in clz_normalizer.

Test Plan:
- Reset, then start with a=0x80000000 → done in cycle 2, result=0x80000000, count=0, zero=0, busy high cycles 1-2.
- a=0x00000001, STEP=4 → 8 SHIFT cycles, done in cycle 10, result=0x80000000, count=31; repeat with STEP=16 → done in cycle 4.
- a=0x00000000 → done in cycle 2, count=32, zero=1, result=0x00000000, no SHIFT state entered.
- a=0x00F0_1234 with start held high for 6 cycles → only one done pulse, result=0xF0123400, count=8, done in cycle 4 (STEP=4); the extra starts are ignored.
- a=0x00000003, reset asserted in cycle 3 (mid-SHIFT) → no done pulse, all outputs 0 next cycle; a new start with a=0x40000000 → count=1, result=0x80000000, done in cycle 3.
- Back-to-back: start a=0x0000FFFF, then start again in the first IDLE cycle after done with a=0x10000000 → first result 0xFFFF0000/count 16, second result 0x80000000/count 3; result holds between operations.
